fwd_hazard_tracker: RTL and testbench

Parametrised forwarding and load-use hazard unit for the ARM pipeline. It keeps its own shift-register record of in-flight producers (destination, write-enable, load flag) over DEPTH post-issue stages. For every source operand of the instruction in ID it selects the youngest matching producer, or raises a stall when that producer's data is not yet available. It replaces the fixed two-source, two-stage forwarding logic, adds a no-forwarding mode and saturating performance counters, and sits beside the hazard/ID stage driving the EXE operand muxes and the pipeline stall.

---
 rtl/fwd_hazard_tracker.sv | 102 ++++++++++
 tb/tb_fwd_hazard_tracker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard unit: tracks in-flight producers over DEPTH
// post-issue stages and picks the youngest forwarding source per ID operand.
module fwd_hazard_tracker #(
  parameter int REG_W      = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_en,
  input  logic                     freeze,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_dest,
  input  logic                     issue_wb_en,
  input  logic                     issue_mem_read,
  input  logic [NUM_SRC*REG_W-1:0] src_flat,
  input  logic [NUM_SRC-1:0]       src_used,
  output logic [NUM_SRC*SEL_W-1:0] sel_flat,
  output logic                     stall,
  output logic                     forwarded,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         fwd_cnt
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_wb_en;
  logic [DEPTH-1:0] ent_load;
  logic [REG_W-1:0] ent_dest [DEPTH];

  logic             op_hit   [NUM_SRC];
  logic             op_load  [NUM_SRC];
  logic [SEL_W-1:0] op_stage [NUM_SRC];

  // Scan oldest to youngest so the youngest matching stage is the one kept.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      op_hit[i]   = 1'b0;
      op_load[i]  = 1'b0;
      op_stage[i] = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (ent_valid[s] && ent_wb_en[s] && src_used[i] &&
            (ent_dest[s] == src_flat[i*REG_W +: REG_W])) begin
          op_hit[i]   = 1'b1;
          op_load[i]  = ent_load[s];
          op_stage[i] = SEL_W'(s);
        end
      end
    end
  end

  always_comb begin
    sel_flat = '0;
    stall    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (op_hit[i]) begin
        if (!fwd_en) begin
          stall = 1'b1;
        end else if (op_load[i] && (int'(op_stage[i]) < LOAD_STAGE)) begin
          stall = 1'b1;
        end else begin
          sel_flat[i*SEL_W +: SEL_W] = op_stage[i] + SEL_W'(1);
        end
      end
    end
    forwarded = |sel_flat;
  end

  // A stalled issue enters stage 0 as a bubble; freeze holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_wb_en <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_dest[k] <= '0;
      end
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!freeze) begin
      ent_valid[0] <= issue_valid & ~stall;
      ent_wb_en[0] <= issue_wb_en;
      ent_load[0]  <= issue_mem_read;
      ent_dest[0]  <= issue_dest;
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_wb_en[k] <= ent_wb_en[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_dest[k]  <= ent_dest[k-1];
      end
      if (issue_valid && stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (issue_valid && !stall && forwarded && (fwd_cnt != '1)) begin
        fwd_cnt <= fwd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: hand-derived expectations are queued
// when each step is driven and popped when outputs are sampled on the falling edge.
module tb_fwd_hazard_tracker;

  localparam int REG_W   = 4;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int CNT_W   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en;
  logic       freeze;
  logic       issue_valid;
  logic [3:0] issue_dest;
  logic       issue_wb_en;
  logic       issue_mem_read;
  logic [7:0] src_flat;
  logic [1:0] src_used;
  logic [3:0] sel_flat;
  logic       stall;
  logic       forwarded;
  logic [2:0] stall_cnt;
  logic [2:0] fwd_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       stall;
    logic       fwd;
    logic [2:0] scnt;
    logic [2:0] fcnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  fwd_hazard_tracker #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_STAGE(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .freeze(freeze),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read),
    .src_flat(src_flat), .src_used(src_used), .sel_flat(sel_flat),
    .stall(stall), .forwarded(forwarded),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  task automatic apply_stimulus(input string tag, input logic fe, input logic frz,
                                input logic iv, input logic [3:0] dest, input logic wb,
                                input logic mr, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [1:0] used, input logic [1:0] e_sel0,
                                input logic [1:0] e_sel1, input logic e_stall,
                                input logic e_fwd, input logic [2:0] e_scnt,
                                input logic [2:0] e_fcnt);
    exp_t e;
    fwd_en         = fe;
    freeze         = frz;
    issue_valid    = iv;
    issue_dest     = dest;
    issue_wb_en    = wb;
    issue_mem_read = mr;
    src_flat       = {s1, s0};
    src_used       = used;
    e.tag   = tag;
    e.sel0  = e_sel0;
    e.sel1  = e_sel1;
    e.stall = e_stall;
    e.fwd   = e_fwd;
    e.scnt  = e_scnt;
    e.fcnt  = e_fcnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string name, input logic [7:0] got,
                     input logic [7:0] exp_v);
    checks++;
    assert (got === exp_v) else begin
      failures++;
      $error("[TB] FAIL %s.%s got=%0d expected=%0d", tag, name, got, exp_v);
    end
  endtask

  task automatic check_output();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty got=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, "sel0",      {6'b0, sel_flat[1:0]}, {6'b0, e.sel0});
      chk(e.tag, "sel1",      {6'b0, sel_flat[3:2]}, {6'b0, e.sel1});
      chk(e.tag, "stall",     {7'b0, stall},         {7'b0, e.stall});
      chk(e.tag, "forwarded", {7'b0, forwarded},     {7'b0, e.fwd});
      chk(e.tag, "stall_cnt", {5'b0, stall_cnt},     {5'b0, e.scnt});
      chk(e.tag, "fwd_cnt",   {5'b0, fwd_cnt},       {5'b0, e.fcnt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic fe, input logic frz, input logic iv,
                      input logic [3:0] dest, input logic wb, input logic mr,
                      input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                      input logic [1:0] e_sel0, input logic [1:0] e_sel1,
                      input logic e_stall, input logic e_fwd,
                      input logic [2:0] e_scnt, input logic [2:0] e_fcnt);
    apply_stimulus(tag, fe, frz, iv, dest, wb, mr, s0, s1, used,
                   e_sel0, e_sel1, e_stall, e_fwd, e_scnt, e_fcnt);
    check_output();
  endtask

  initial begin
    rst            = 1'b1;
    fwd_en         = 1'($urandom);
    freeze         = 1'($urandom);
    issue_valid    = 1'($urandom);
    issue_dest     = 4'($urandom);
    issue_wb_en    = 1'($urandom);
    issue_mem_read = 1'($urandom);
    src_flat       = 8'($urandom);
    src_used       = 2'($urandom);
    @(posedge clk);
    #1;
    apply_stimulus("reset", 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                   1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
                   0, 0, 0, 0, 0, 0);
    check_output();
    rst = 1'b0;

    step("first_issue",  1, 0, 1, 3, 1, 0, 3, 3, 2'b11, 0, 0, 0, 0, 0, 0);
    step("alu_b2b",      1, 0, 1, 7, 0, 0, 3, 3, 2'b01, 1, 0, 0, 1, 0, 0);
    step("alu_stage1",   1, 0, 0, 0, 0, 0, 3, 3, 2'b01, 2, 0, 0, 1, 0, 1);
    step("alu_stage2",   1, 0, 0, 0, 0, 0, 3, 3, 2'b01, 3, 0, 0, 1, 0, 1);
    step("alu_gone",     1, 0, 0, 0, 0, 0, 3, 3, 2'b01, 0, 0, 0, 0, 0, 1);

    step("load_issue",   1, 0, 1, 5, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    step("load_stall",   1, 0, 1, 8, 1, 0, 0, 5, 2'b10, 0, 0, 1, 0, 0, 1);
    step("load_fwd",     1, 0, 1, 8, 1, 0, 0, 5, 2'b10, 0, 2, 0, 1, 1, 1);
    step("idle_a",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);

    step("r2_first",     1, 0, 1, 2, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);
    step("r9",           1, 0, 1, 9, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);
    step("r2_second",    1, 0, 1, 2, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);
    step("src_unused",   1, 1, 0, 0, 0, 0, 2, 2, 2'b00, 0, 0, 0, 0, 1, 2);
    step("youngest",     1, 0, 0, 0, 0, 0, 2, 2, 2'b11, 1, 1, 0, 1, 1, 2);
    step("r2_stage1",    1, 0, 0, 0, 0, 0, 2, 2, 2'b01, 2, 0, 0, 1, 1, 2);
    step("idle_b",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);

    step("nofwd_issue",  0, 0, 1, 4, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);
    step("nofwd_st0",    0, 0, 1, 10, 1, 0, 4, 0, 2'b01, 0, 0, 1, 0, 1, 2);
    step("nofwd_st1",    0, 0, 1, 10, 1, 0, 4, 0, 2'b01, 0, 0, 1, 0, 2, 2);
    step("nofwd_st2",    0, 0, 1, 10, 1, 0, 4, 0, 2'b01, 0, 0, 1, 0, 3, 2);
    step("nofwd_go",     0, 0, 1, 10, 1, 0, 4, 0, 2'b01, 0, 0, 0, 0, 4, 2);
    step("r10_fwd",      1, 0, 0, 0, 0, 0, 10, 0, 2'b01, 1, 0, 0, 1, 4, 2);
    step("idle_c",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4, 2);
    step("idle_d",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4, 2);

    step("load6_issue",  1, 0, 1, 6, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4, 2);
    for (int i = 0; i < 4; i++) begin
      step("freeze_hold", 1, 1, 1, 11, 1, 0, 6, 0, 2'b01, 0, 0, 1, 0, 4, 2);
    end
    step("freeze_rel",   1, 0, 1, 11, 1, 0, 6, 0, 2'b01, 0, 0, 1, 0, 4, 2);
    step("load6_fwd",    1, 0, 1, 11, 1, 0, 6, 0, 2'b01, 2, 0, 0, 1, 5, 2);

    for (int k = 0; k < 6; k++) begin
      step("fwd_sat", 1, 0, 1, 12, 1, 0, (k == 0) ? 4'd11 : 4'd12, 0, 2'b01,
           1, 0, 0, 1, 5, ((3 + k) > 7) ? 3'd7 : 3'(3 + k));
    end

    step("load13",       1, 0, 1, 13, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 5, 7);
    for (int j = 0; j < 6; j++) begin
      if (j % 2 == 0) begin
        step("stall_sat_st", 1, 0, 1, 13, 1, 1, 13, 0, 2'b01, 0, 0, 1, 0,
             ((5 + j / 2) > 7) ? 3'd7 : 3'(5 + j / 2), 7);
      end else begin
        step("stall_sat_fw", 1, 0, 1, 13, 1, 1, 13, 0, 2'b01, 2, 0, 0, 1,
             ((5 + (j + 1) / 2) > 7) ? 3'd7 : 3'(5 + (j + 1) / 2), 7);
      end
    end
    step("sat_hold",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 7, 7);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("mid_reset",    1, 0, 0, 0, 0, 0, 13, 13, 2'b11, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
